// File: rtl/tomasulo_pkg.sv
// Shared widths, tag constants and opcodes for the Tomasulo core.
// Imported by the rename-table top and its operand resolver.
package tomasulo_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int NUM_REGS_DEF = 1 << REG_IDX_W;
    localparam int DATA_W_DEF   = 8;
    localparam int TAG_W_DEF    = 3;

    // Tag 0 is never handed to a station; it marks "no producer".
    localparam int NO_TAG = 0;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_LD  = 4'd4,
        OP_ST  = 4'd5
    } opcode_t;

endpackage

// File: rtl/reg_status_table_rst_lookup.sv
// Source-operand resolver: older-slot forwarding, then CDB bypass,
// then the table entry itself.
module rst_lookup
    import tomasulo_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int RIDX_W  = REG_IDX_W,
    parameter int ISSUE_W = 2,
    parameter int CDB_W   = 2,
    parameter int SLOT    = 0
)(
    input  logic [RIDX_W-1:0]         i_src,
    input  logic [ISSUE_W-1:0]        i_iss_valid,
    input  logic [ISSUE_W-1:0]        i_iss_dst_we,
    input  logic [ISSUE_W*RIDX_W-1:0] i_iss_dst,
    input  logic [ISSUE_W*TAG_W-1:0]  i_iss_tag,
    input  logic [CDB_W-1:0]          i_cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]    i_cdb_tag,
    input  logic [CDB_W*DATA_W-1:0]   i_cdb_data,
    input  logic [DATA_W-1:0]         i_ent_data,
    input  logic                      i_ent_busy,
    input  logic [TAG_W-1:0]          i_ent_tag,
    output logic [DATA_W-1:0]         o_val,
    output logic [TAG_W-1:0]          o_tag,
    output logic                      o_vbit
);

    logic              w_fwd;
    logic [TAG_W-1:0]  w_fwd_tag;
    logic              w_byp;
    logic [DATA_W-1:0] w_byp_val;

    always_comb begin
        w_fwd     = 1'b0;
        w_fwd_tag = '0;
        // Ascending scan: the youngest older writer is the last to hit.
        for (int j = 0; j < SLOT; j++) begin
            if (i_iss_valid[SLOT] && i_iss_valid[j] && i_iss_dst_we[j] &&
                i_iss_dst[j*RIDX_W +: RIDX_W] == i_src) begin
                w_fwd     = 1'b1;
                w_fwd_tag = i_iss_tag[j*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        w_byp     = 1'b0;
        w_byp_val = '0;
        // Descending scan so the lowest bus index wins a duplicate tag.
        for (int c = CDB_W - 1; c >= 0; c--) begin
            if (i_cdb_valid[c] &&
                i_cdb_tag[c*TAG_W +: TAG_W] == i_ent_tag) begin
                w_byp     = 1'b1;
                w_byp_val = i_cdb_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        o_val  = i_ent_data;
        o_tag  = TAG_W'(NO_TAG);
        o_vbit = 1'b1;
        if (w_fwd) begin
            o_vbit = 1'b0;
            o_tag  = w_fwd_tag;
        end else if (i_ent_busy) begin
            if (w_byp) begin
                o_val = w_byp_val;
            end else begin
                o_vbit = 1'b0;
                o_tag  = i_ent_tag;
            end
        end
    end

endmodule

// File: rtl/reg_status_table.sv
// Register status (rename) table: value, busy bit and producer tag
// per architectural register, with multi-issue rename and CDB snoop.
module reg_status_table
    import tomasulo_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int ISSUE_W  = 2,
    parameter int CDB_W    = 2,
    localparam int RIDX_W  = $clog2(NUM_REGS)
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [ISSUE_W-1:0]        iss_valid,
    input  logic [ISSUE_W*RIDX_W-1:0] iss_src_a,
    input  logic [ISSUE_W*RIDX_W-1:0] iss_src_b,
    input  logic [ISSUE_W*RIDX_W-1:0] iss_dst,
    input  logic [ISSUE_W-1:0]        iss_dst_we,
    input  logic [ISSUE_W*TAG_W-1:0]  iss_tag,
    input  logic [CDB_W-1:0]          cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_W*DATA_W-1:0]   cdb_data,
    output logic [ISSUE_W*DATA_W-1:0] opa_val,
    output logic [ISSUE_W*DATA_W-1:0] opb_val,
    output logic [ISSUE_W*TAG_W-1:0]  opa_tag,
    output logic [ISSUE_W*TAG_W-1:0]  opb_tag,
    output logic [ISSUE_W-1:0]        opa_vbit,
    output logic [ISSUE_W-1:0]        opb_vbit
);

    logic [NUM_REGS-1:0][DATA_W-1:0] w_data;
    logic [NUM_REGS-1:0]             w_busy;
    logic [NUM_REGS-1:0][TAG_W-1:0]  w_tag;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_ent
        logic [DATA_W-1:0] r_data;
        logic              r_busy;
        logic [TAG_W-1:0]  r_tag;
        logic              w_cdb_hit;
        logic [DATA_W-1:0] w_cdb_val;
        logic              w_ren_hit;
        logic [TAG_W-1:0]  w_ren_tag;

        always_comb begin
            w_cdb_hit = 1'b0;
            w_cdb_val = '0;
            for (int c = CDB_W - 1; c >= 0; c--) begin
                if (cdb_valid[c] &&
                    cdb_tag[c*TAG_W +: TAG_W] == r_tag) begin
                    w_cdb_hit = 1'b1;
                    w_cdb_val = cdb_data[c*DATA_W +: DATA_W];
                end
            end
        end

        always_comb begin
            w_ren_hit = 1'b0;
            w_ren_tag = '0;
            for (int s = 0; s < ISSUE_W; s++) begin
                if (iss_valid[s] && iss_dst_we[s] &&
                    iss_dst[s*RIDX_W +: RIDX_W] == RIDX_W'(i)) begin
                    w_ren_hit = 1'b1;
                    w_ren_tag = iss_tag[s*TAG_W +: TAG_W];
                end
            end
        end

        // Rename is applied after capture so it owns busy/tag,
        // while the captured value still lands in the data field.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data <= DATA_W'(i);
                r_busy <= 1'b0;
                r_tag  <= TAG_W'(NO_TAG);
            end else if (flush) begin
                r_busy <= 1'b0;
                r_tag  <= TAG_W'(NO_TAG);
            end else begin
                if (r_busy && w_cdb_hit) begin
                    r_data <= w_cdb_val;
                    r_busy <= 1'b0;
                end
                if (w_ren_hit) begin
                    r_busy <= 1'b1;
                    r_tag  <= w_ren_tag;
                end
            end
        end

        assign w_data[i] = r_data;
        assign w_busy[i] = r_busy;
        assign w_tag[i]  = r_tag;
    end

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
        logic [RIDX_W-1:0] w_sa;
        logic [RIDX_W-1:0] w_sb;

        assign w_sa = iss_src_a[k*RIDX_W +: RIDX_W];
        assign w_sb = iss_src_b[k*RIDX_W +: RIDX_W];

        rst_lookup #(
            .DATA_W  (DATA_W),
            .TAG_W   (TAG_W),
            .RIDX_W  (RIDX_W),
            .ISSUE_W (ISSUE_W),
            .CDB_W   (CDB_W),
            .SLOT    (k)
        ) u_opa (
            .i_src        (w_sa),
            .i_iss_valid  (iss_valid),
            .i_iss_dst_we (iss_dst_we),
            .i_iss_dst    (iss_dst),
            .i_iss_tag    (iss_tag),
            .i_cdb_valid  (cdb_valid),
            .i_cdb_tag    (cdb_tag),
            .i_cdb_data   (cdb_data),
            .i_ent_data   (w_data[w_sa]),
            .i_ent_busy   (w_busy[w_sa]),
            .i_ent_tag    (w_tag[w_sa]),
            .o_val        (opa_val[k*DATA_W +: DATA_W]),
            .o_tag        (opa_tag[k*TAG_W +: TAG_W]),
            .o_vbit       (opa_vbit[k])
        );

        rst_lookup #(
            .DATA_W  (DATA_W),
            .TAG_W   (TAG_W),
            .RIDX_W  (RIDX_W),
            .ISSUE_W (ISSUE_W),
            .CDB_W   (CDB_W),
            .SLOT    (k)
        ) u_opb (
            .i_src        (w_sb),
            .i_iss_valid  (iss_valid),
            .i_iss_dst_we (iss_dst_we),
            .i_iss_dst    (iss_dst),
            .i_iss_tag    (iss_tag),
            .i_cdb_valid  (cdb_valid),
            .i_cdb_tag    (cdb_tag),
            .i_cdb_data   (cdb_data),
            .i_ent_data   (w_data[w_sb]),
            .i_ent_busy   (w_busy[w_sb]),
            .i_ent_tag    (w_tag[w_sb]),
            .o_val        (opb_val[k*DATA_W +: DATA_W]),
            .o_tag        (opb_tag[k*TAG_W +: TAG_W]),
            .o_vbit       (opb_vbit[k])
        );
    end

endmodule

// File: tb/tb_reg_status_table.sv
// Bench for reg_status_table: directed scenarios plus random traffic
// checked against an array-based model of the rename table.
module tb_reg_status_table;

    localparam int NR = 32;
    localparam int RW = 5;
    localparam int DW = 8;
    localparam int TW = 3;
    localparam int IW = 2;
    localparam int CW = 2;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic [IW-1:0]  iss_valid;
    logic [IW*RW-1:0] iss_src_a;
    logic [IW*RW-1:0] iss_src_b;
    logic [IW*RW-1:0] iss_dst;
    logic [IW-1:0]  iss_dst_we;
    logic [IW*TW-1:0] iss_tag;
    logic [CW-1:0]  cdb_valid;
    logic [CW*TW-1:0] cdb_tag;
    logic [CW*DW-1:0] cdb_data;
    logic [IW*DW-1:0] opa_val;
    logic [IW*DW-1:0] opb_val;
    logic [IW*TW-1:0] opa_tag;
    logic [IW*TW-1:0] opb_tag;
    logic [IW-1:0]  opa_vbit;
    logic [IW-1:0]  opb_vbit;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_data [NR];
    logic          m_busy [NR];
    logic [TW-1:0] m_tag  [NR];

    reg_status_table #(
        .NUM_REGS (NR),
        .DATA_W   (DW),
        .TAG_W    (TW),
        .ISSUE_W  (IW),
        .CDB_W    (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .iss_valid  (iss_valid),
        .iss_src_a  (iss_src_a),
        .iss_src_b  (iss_src_b),
        .iss_dst    (iss_dst),
        .iss_dst_we (iss_dst_we),
        .iss_tag    (iss_tag),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .opa_val    (opa_val),
        .opb_val    (opb_val),
        .opa_tag    (opa_tag),
        .opb_tag    (opb_tag),
        .opa_vbit   (opa_vbit),
        .opb_vbit   (opb_vbit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_data[r] = DW'(r);
            m_busy[r] = 1'b0;
            m_tag[r]  = '0;
        end
    endtask

    task automatic clear_inputs();
        flush = 0; iss_valid = '0; iss_src_a = '0; iss_src_b = '0;
        iss_dst = '0; iss_dst_we = '0; iss_tag = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic set_slot(input int k, input bit v, input int a,
                            input int b, input int d, input bit we,
                            input int t);
        iss_valid[k]          = v;
        iss_src_a[k*RW +: RW] = RW'(a);
        iss_src_b[k*RW +: RW] = RW'(b);
        iss_dst[k*RW +: RW]   = RW'(d);
        iss_dst_we[k]         = we;
        iss_tag[k*TW +: TW]   = TW'(t);
    endtask

    task automatic set_cdb(input int c, input bit v, input int t,
                           input int d);
        cdb_valid[c]          = v;
        cdb_tag[c*TW +: TW]   = TW'(t);
        cdb_data[c*DW +: DW]  = DW'(d);
    endtask

    // Next state from the rules: flush wipes busy/tag; else a matching
    // broadcast (first bus) fills the value, and the youngest renamer
    // takes ownership of busy/tag.
    task automatic tick();
        logic [DW-1:0] nd [NR];
        logic          nb [NR];
        logic [TW-1:0] nt [NR];
        for (int r = 0; r < NR; r++) begin
            bit got = 0;
            nd[r] = m_data[r]; nb[r] = m_busy[r]; nt[r] = m_tag[r];
            if (flush) begin
                nb[r] = 0; nt[r] = '0;
            end else begin
                if (m_busy[r])
                    for (int c = 0; c < CW; c++)
                        if (!got && cdb_valid[c] &&
                            cdb_tag[c*TW +: TW] == m_tag[r]) begin
                            nd[r] = cdb_data[c*DW +: DW]; nb[r] = 0; got = 1;
                        end
                got = 0;
                for (int s = IW - 1; s >= 0; s--)
                    if (!got && iss_valid[s] && iss_dst_we[s] &&
                        iss_dst[s*RW +: RW] == RW'(r)) begin
                        nb[r] = 1; nt[r] = iss_tag[s*TW +: TW]; got = 1;
                    end
            end
        end
        @(posedge clk);
        for (int r = 0; r < NR; r++) begin
            m_data[r] = nd[r]; m_busy[r] = nb[r]; m_tag[r] = nt[r];
        end
        #1;
    endtask

    function automatic void exp_op(input int k, input int src,
                                   output logic v,
                                   output logic [DW-1:0] val,
                                   output logic [TW-1:0] tag);
        bit done = 0;
        v = 1; val = m_data[src]; tag = '0;
        if (iss_valid[k])
            for (int j = k - 1; j >= 0; j--)
                if (!done && iss_valid[j] && iss_dst_we[j] &&
                    iss_dst[j*RW +: RW] == RW'(src)) begin
                    v = 0; tag = iss_tag[j*TW +: TW]; done = 1;
                end
        if (!done && m_busy[src]) begin
            v = 0; tag = m_tag[src];
            for (int c = 0; c < CW; c++)
                if (!done && cdb_valid[c] &&
                    cdb_tag[c*TW +: TW] == m_tag[src]) begin
                    v = 1; tag = '0; val = cdb_data[c*DW +: DW]; done = 1;
                end
        end
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        #12 rst_n = 1;
        @(negedge clk);
        set_slot(0, 1, 0, 1, 0, 0, 0);
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b1 || opa_val[7:0] !== 8'h00 ||
            opa_tag[2:0] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_r0: v=%0b val=%02h tag=%0d, want 1/00/0",
                     opa_vbit[0], opa_val[7:0], opa_tag[2:0]);
        end
        n_tests++;
        if (opb_vbit[0] !== 1'b1 || opb_val[7:0] !== 8'h01 ||
            opb_tag[2:0] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_r1: v=%0b val=%02h tag=%0d, want 1/01/0",
                     opb_vbit[0], opb_val[7:0], opb_tag[2:0]);
        end
    endtask

    task automatic test_rename_cdb();
        clear_inputs();
        set_slot(0, 1, 0, 1, 2, 1, 5);
        tick();
        clear_inputs();
        set_slot(0, 1, 2, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b0 || opa_tag[2:0] !== 3'd5) begin
            n_fail++;
            $display("FAIL rename_busy: v=%0b tag=%0d, want 0/5",
                     opa_vbit[0], opa_tag[2:0]);
        end
        set_cdb(0, 1, 5, 8'h14);
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b1 || opa_val[7:0] !== 8'h14 ||
            opa_tag[2:0] !== 3'd0) begin
            n_fail++;
            $display("FAIL cdb_bypass: v=%0b val=%02h tag=%0d, want 1/14/0",
                     opa_vbit[0], opa_val[7:0], opa_tag[2:0]);
        end
        tick();
        set_cdb(0, 0, 0, 0);
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b1 || opa_val[7:0] !== 8'h14) begin
            n_fail++;
            $display("FAIL cdb_capture: v=%0b val=%02h, want 1/14",
                     opa_vbit[0], opa_val[7:0]);
        end
    endtask

    task automatic test_intra_bundle();
        clear_inputs();
        set_slot(0, 1, 3, 4, 5, 1, 1);
        set_slot(1, 1, 5, 0, 5, 1, 2);
        #1;
        n_tests++;
        if (opa_vbit[1] !== 1'b0 || opa_tag[5:3] !== 3'd1) begin
            n_fail++;
            $display("FAIL intra_fwd: v=%0b tag=%0d, want 0/1",
                     opa_vbit[1], opa_tag[5:3]);
        end
        tick();
        clear_inputs();
        set_slot(0, 1, 5, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b0 || opa_tag[2:0] !== 3'd2) begin
            n_fail++;
            $display("FAIL youngest_rename: v=%0b tag=%0d, want 0/2",
                     opa_vbit[0], opa_tag[2:0]);
        end
    endtask

    task automatic test_rename_over_cdb();
        clear_inputs();
        set_slot(0, 1, 0, 0, 6, 1, 3);
        tick();
        set_slot(0, 1, 6, 0, 6, 1, 4);
        set_cdb(0, 1, 3, 8'h5A);
        tick();
        clear_inputs();
        set_slot(0, 1, 6, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b0 || opa_tag[2:0] !== 3'd4) begin
            n_fail++;
            $display("FAIL rename_wins: v=%0b tag=%0d, want 0/4",
                     opa_vbit[0], opa_tag[2:0]);
        end
        flush = 1;
        tick();
        flush = 0;
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b1 || opa_val[7:0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL data_kept: v=%0b val=%02h, want 1/5a",
                     opa_vbit[0], opa_val[7:0]);
        end
    endtask

    task automatic test_dual_cdb();
        clear_inputs();
        set_slot(0, 1, 0, 0, 8, 1, 1);
        set_slot(1, 1, 0, 0, 9, 1, 6);
        tick();
        clear_inputs();
        set_cdb(0, 1, 1, 8'h81);
        set_cdb(1, 1, 6, 8'h96);
        tick();
        clear_inputs();
        set_slot(0, 1, 8, 9, 0, 0, 0);
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b1 || opa_val[7:0] !== 8'h81 ||
            opb_vbit[0] !== 1'b1 || opb_val[7:0] !== 8'h96) begin
            n_fail++;
            $display("FAIL dual_cdb: a=%0b/%02h b=%0b/%02h, want 1/81 1/96",
                     opa_vbit[0], opa_val[7:0], opb_vbit[0], opb_val[7:0]);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        set_slot(0, 1, 0, 0, 10, 1, 2);
        set_slot(1, 1, 0, 0, 11, 1, 3);
        tick();
        clear_inputs();
        set_slot(0, 1, 0, 0, 12, 1, 7);
        tick();
        clear_inputs();
        flush = 1;
        set_slot(0, 1, 10, 11, 0, 0, 0);
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b0 || opa_tag[2:0] !== 3'd2) begin
            n_fail++;
            $display("FAIL flush_cycle_lookup: v=%0b tag=%0d, want 0/2",
                     opa_vbit[0], opa_tag[2:0]);
        end
        tick();
        flush = 0;
        set_slot(1, 1, 12, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b1 || opa_val[7:0] !== 8'd10 ||
            opb_vbit[0] !== 1'b1 || opb_val[7:0] !== 8'd11 ||
            opa_vbit[1] !== 1'b1 || opa_val[15:8] !== 8'd12) begin
            n_fail++;
            $display("FAIL flush_clear: %0b/%0d %0b/%0d %0b/%0d, want 1/10 1/11 1/12",
                     opa_vbit[0], opa_val[7:0], opb_vbit[0], opb_val[7:0],
                     opa_vbit[1], opa_val[15:8]);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        set_slot(0, 1, 0, 0, 0, 1, 7);
        tick();
        clear_inputs();
        set_slot(0, 1, 0, 2, 0, 0, 0);
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b0 || opa_tag[2:0] !== 3'd7) begin
            n_fail++;
            $display("FAIL pre_reset_busy: v=%0b tag=%0d, want 0/7",
                     opa_vbit[0], opa_tag[2:0]);
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        n_tests++;
        if (opa_vbit[0] !== 1'b1 || opa_val[7:0] !== 8'h00 ||
            opa_tag[2:0] !== 3'd0 || opb_val[7:0] !== 8'h02) begin
            n_fail++;
            $display("FAIL async_reset: v=%0b val=%02h tag=%0d r2=%02h, want 1/00/0/02",
                     opa_vbit[0], opa_val[7:0], opa_tag[2:0], opb_val[7:0]);
        end
        #2 rst_n = 1;
    endtask

    task automatic test_random();
        logic          ev;
        logic [DW-1:0] eval;
        logic [TW-1:0] etag;
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            flush = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < IW; k++)
                set_slot(k, $urandom_range(0, 3) != 0,
                         $urandom_range(0, 7), $urandom_range(0, NR - 1),
                         $urandom_range(0, 7), 1'($urandom),
                         $urandom_range(1, 7));
            for (int c = 0; c < CW; c++)
                set_cdb(c, 1'($urandom), $urandom_range(1, 7),
                        $urandom_range(0, 255));
            #1;
            for (int k = 0; k < IW; k++) begin
                if (iss_valid[k]) begin
                    exp_op(k, int'(iss_src_a[k*RW +: RW]), ev, eval, etag);
                    n_tests++;
                    if (opa_vbit[k] !== ev || opa_tag[k*TW +: TW] !== etag ||
                        (ev && opa_val[k*DW +: DW] !== eval)) begin
                        n_fail++;
                        $display("FAIL rand_opa s%0d n%0d: %0b/%02h/%0d, want %0b/%02h/%0d",
                                 k, n, opa_vbit[k], opa_val[k*DW +: DW],
                                 opa_tag[k*TW +: TW], ev, eval, etag);
                    end
                    exp_op(k, int'(iss_src_b[k*RW +: RW]), ev, eval, etag);
                    n_tests++;
                    if (opb_vbit[k] !== ev || opb_tag[k*TW +: TW] !== etag ||
                        (ev && opb_val[k*DW +: DW] !== eval)) begin
                        n_fail++;
                        $display("FAIL rand_opb s%0d n%0d: %0b/%02h/%0d, want %0b/%02h/%0d",
                                 k, n, opb_vbit[k], opb_val[k*DW +: DW],
                                 opb_tag[k*TW +: TW], ev, eval, etag);
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_rename_cdb();
        test_intra_bundle();
        test_rename_over_cdb();
        test_dual_cdb();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_status_table.md
# reg_status_table

Parametrised register status (rename) table for the Tomasulo core. It holds an architectural value, a busy bit and a producer tag for every register. It accepts ISSUE_W instructions per cycle and snoops CDB_W common-data-bus broadcasts per cycle. It sits between the decode/issue stage and the reservation stations, supplying each source operand as either a ready value or the tag of the station that will produce it.

## Interface
- NUM_REGS, 32: architectural register count; index width RIDX_W = $clog2(NUM_REGS).
- DATA_W, 8: register/operand data width.
- TAG_W, 3: reservation-station tag width.
- ISSUE_W, 2: issue slots per cycle; slot 0 is oldest in program order.
- CDB_W, 2: result broadcast buses.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous; clears every busy bit (mispredict recovery).
- iss_valid  in  ISSUE_W  slot carries an instruction.
- iss_src_a, iss_src_b  in  ISSUE_W*RIDX_W  source register indices per slot.
- iss_dst  in  ISSUE_W*RIDX_W  destination index per slot.
- iss_dst_we  in  ISSUE_W  slot writes a destination.
- iss_tag  in  ISSUE_W*TAG_W  tag of the station allocated to the slot.
- cdb_valid  in  CDB_W  broadcast present.
- cdb_tag  in  CDB_W*TAG_W  producing tag.
- cdb_data  in  CDB_W*DATA_W  result value.
- opa_val, opb_val  out  ISSUE_W*DATA_W  operand value (meaningful when vbit=1).
- opa_tag, opb_tag  out  ISSUE_W*TAG_W  pending producer tag (meaningful when vbit=0; 0 when vbit=1).
- opa_vbit, opb_vbit  out  ISSUE_W  1 = operand ready.

## Operation
- Per entry: data[DATA_W], busy, tag[TAG_W].
- Reset: data[i] = i truncated to DATA_W; busy = 0; tag = 0.
- Operand lookup is combinational, with precedence highest first:
  - Intra-bundle forwarding: the youngest older slot j<k with iss_valid & iss_dst_we and iss_dst[j]==src. Returns vbit=0, tag=iss_tag[j].
  - CDB bypass: the entry is busy and some cdb_valid[c] has cdb_tag[c]==entry tag. Returns vbit=1 with cdb_data[c].
  - Table: busy gives vbit=0 with the entry tag; otherwise vbit=1 with the entry data.
- Clock edge update, per entry:
  - CDB capture: if busy and a valid broadcast matches its tag, write data from that broadcast and clear busy.
  - Rename: if any valid slot with iss_dst_we targets the entry, set busy=1 and tag=the youngest such slot's tag.
  - Rename overrides CDB capture for busy/tag. Data is still captured from the CDB, so the architectural value remains current.
- Multiple CDBs with the same tag in one cycle is illegal. If it happens, the lowest CDB index wins.
- flush: all busy cleared and tags zeroed on the edge. Data is kept. Same-cycle issue and CDB writes are ignored. Outputs during the flush cycle still follow the lookup rules above.
- Slots with iss_valid=0 have no effect and their outputs are don't-care. They are driven as the table lookup.

## Timing
- Lookup latency: 0 cycles (combinational). Updates are visible from the cycle after the edge.
- A broadcast in cycle t is readable by issue in cycle t via bypass, and from the table in t+1.
- There is no back-pressure. The table accepts every slot every cycle.
- Reset asserted mid-operation clears state immediately, independent of clk. Outputs revert to the lookup of the reset contents.

## Structure
- The shared package (tomasulo_pkg) holds: the register index, tag and data widths; the reserved NO_TAG=0 constant; and the opcode defines already used by the core.
- Sub-module rst_lookup: one combinational source-operand resolver (forwarding, bypass, table). It is instantiated 2*ISSUE_W times.
- The entry array and update logic live in the top module as a generate loop over NUM_REGS.

## Test plan
- Reset, then read R0/R1 in slot 0 → vbit=1, val=0x00/0x01, tag=0.
- Slot 0 MUL R2←R0,R1 with tag 5; next cycle slot 0 reads R2 → vbit=0, tag=5. CDB {tag 5, 0x14} → the same cycle bypasses val 0x14, and the next cycle the table gives vbit=1, val 0x14.
- One bundle: slot 0 R5←R3,R4 tag 1; slot 1 reads R5 → slot 1 opa vbit=0, tag=1. Slot 1 dst R5 tag 2 → R5 ends busy with tag 2.
- CDB for tag 3 while slot 0 renames the same register to tag 4 → entry stays busy with tag 4, and data holds the CDB value.
- Two CDBs (tags 1 and 6) targeting R8 and R9 in one cycle → both are captured and both are not busy next cycle.
- Multiple registers busy, then flush → all read vbit=1 with their previous data. rst_n pulsed between clock edges → immediate return to reset contents.
